rle_decode_ctrl: RTL and testbench

Sequencer that drives the RLE decoder from a compressed-pair memory and writes the expanded pixel stream into the frame buffer. On `start` it reads `num_pairs` (pixel, count) pairs from memory one at a time. For each pair it issues a single-cycle `valid_in` beat to the decoder, then collects exactly `count` decoded pixels before fetching the next pair. It sits between the compressed-image store, the `rle_decoder` instance and the frame-buffer write port, and reports completion, pixel total and errors to the top-level control.

---
 rtl/rle_decode_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_rle_decode_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decode_ctrl.sv
// rle_decode_ctrl
//   Fetches (pixel, count) pairs from the compressed-image memory, hands each
//   non-empty pair to the RLE decoder as a single valid beat, and writes the
//   expanded pixels it returns into the frame buffer.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   start/num_pairs : frame request, accepted only when idle
//   cmem_*          : compressed-memory read port (data one cycle after cmem_rd)
//   dec_*           : decoder input beat and decoder pixel stream
//   fb_*            : frame-buffer write port (registered)
//   busy/done/error : frame status; error is the sticky overflow flag
//   pix_total       : pixels written in the current/last frame (saturating)
//
// Build option
//   RLE_CTRL_OVERFLOW_CHECK_EN : stop the frame with error once FRAME_PIXELS
//                                pixels have been written. Undefined: no
//                                limit, error stays 0 and fb_addr wraps.

module rle_decode_ctrl #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned FB_ADDR_W    = 10,
    parameter int unsigned FRAME_PIXELS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W:0]      num_pairs,
    output logic                 cmem_rd,
    output logic [ADDR_W-1:0]    cmem_addr,
    input  logic [7:0]           cmem_pixel,
    input  logic [7:0]           cmem_count,
    output logic [7:0]           dec_data,
    output logic [7:0]           dec_count,
    output logic                 dec_valid,
    input  logic [7:0]           dec_pixel,
    input  logic                 dec_valid_out,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [FB_ADDR_W:0]   pix_total
);

    localparam int unsigned PT_W = FB_ADDR_W + 1;
    localparam int unsigned PI_W = ADDR_W + 1;
    localparam logic [PT_W-1:0] PT_MAX      = '1;
    localparam logic [PT_W-1:0] FRAME_LIMIT = PT_W'(FRAME_PIXELS);

`ifdef RLE_CTRL_OVERFLOW_CHECK_EN
    localparam bit OVF_CHECK = 1'b1;
`else
    localparam bit OVF_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_ISSUE,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PI_W-1:0]       pair_idx_q, pair_idx_d;
    logic [PI_W-1:0]       num_pairs_q, num_pairs_d;
    logic [7:0]            cur_pix_q, cur_pix_d;
    logic [7:0]            cur_cnt_q, cur_cnt_d;
    logic [7:0]            run_ctr_q, run_ctr_d;
    logic [FB_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic                  cmem_rd_q, cmem_rd_d;
    logic [ADDR_W-1:0]     cmem_addr_q, cmem_addr_d;
    logic                  dec_valid_q, dec_valid_d;
    logic                  fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]            fb_data_q, fb_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [PT_W-1:0]       pix_total_q, pix_total_d;
    logic                  ovf_c;

    // Frame already full; only reachable when the overflow check is built in
    assign ovf_c = OVF_CHECK && (pix_total_q == FRAME_LIMIT);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pair_idx_d  = pair_idx_q;
        num_pairs_d = num_pairs_q;
        cur_pix_d   = cur_pix_q;
        cur_cnt_d   = cur_cnt_q;
        run_ctr_d   = run_ctr_q;
        wr_ptr_d    = wr_ptr_q;
        cmem_addr_d = cmem_addr_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        error_d     = error_q;
        pix_total_d = pix_total_q;
        fb_we_d     = 1'b0;
        // done trails the DONE state by one cycle, landing as busy drops
        done_d      = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pair_idx_d  = '0;
                    num_pairs_d = num_pairs;
                    wr_ptr_d    = '0;
                    fb_addr_d   = '0;
                    pix_total_d = '0;
                    error_d     = 1'b0;
                    state_d     = (num_pairs == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_RDWAIT;
            end
            S_RDWAIT: begin
                cur_pix_d = cmem_pixel;
                cur_cnt_d = cmem_count;
                // Zero-length runs never reach the decoder
                state_d   = (cmem_count == 8'd0) ? S_NEXT : S_ISSUE;
            end
            S_ISSUE: begin
                run_ctr_d = 8'd0;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (dec_valid_out) begin
                    if (ovf_c) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fb_we_d     = 1'b1;
                        fb_data_d   = dec_pixel;
                        fb_addr_d   = wr_ptr_q;
                        wr_ptr_d    = wr_ptr_q + FB_ADDR_W'(1);
                        pix_total_d = (pix_total_q == PT_MAX) ? pix_total_q
                                                              : pix_total_q + PT_W'(1);
                        run_ctr_d   = run_ctr_q + 8'd1;
                        if ((run_ctr_q + 8'd1) == cur_cnt_q) begin
                            state_d = S_NEXT;
                        end
                    end
                end
            end
            S_NEXT: begin
                pair_idx_d = pair_idx_q + PI_W'(1);
                state_d    = (pair_idx_d == num_pairs_q) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes decoded from the state being entered so they align with it
        cmem_rd_d   = (state_d == S_FETCH);
        dec_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        if (state_d == S_FETCH) begin
            cmem_addr_d = ADDR_W'(pair_idx_d);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pair_idx_q  <= '0;
            num_pairs_q <= '0;
            cur_pix_q   <= '0;
            cur_cnt_q   <= '0;
            run_ctr_q   <= '0;
            wr_ptr_q    <= '0;
            cmem_rd_q   <= 1'b0;
            cmem_addr_q <= '0;
            dec_valid_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            pix_total_q <= '0;
        end else begin
            state_q     <= state_d;
            pair_idx_q  <= pair_idx_d;
            num_pairs_q <= num_pairs_d;
            cur_pix_q   <= cur_pix_d;
            cur_cnt_q   <= cur_cnt_d;
            run_ctr_q   <= run_ctr_d;
            wr_ptr_q    <= wr_ptr_d;
            cmem_rd_q   <= cmem_rd_d;
            cmem_addr_q <= cmem_addr_d;
            dec_valid_q <= dec_valid_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            pix_total_q <= pix_total_d;
        end
    end

    assign cmem_rd   = cmem_rd_q;
    assign cmem_addr = cmem_addr_q;
    // Latched pair doubles as the decoder payload; qualified by dec_valid
    assign dec_data  = cur_pix_q;
    assign dec_count = cur_cnt_q;
    assign dec_valid = dec_valid_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign pix_total = pix_total_q;

endmodule

// File: tb/tb_rle_decode_ctrl.sv
// Bench for rle_decode_ctrl: behavioural compressed memory, RLE decoder and
// frame-buffer write log around the DUT, driven by a table of frames plus
// hand-written timing, reset and stray-input sequences.
// Small widths (4-bit addresses, 16-pixel frame) make wrap and saturation
// reachable; RLE_CTRL_OVERFLOW_CHECK_EN selects the matching expectations.

module tb_rle_decode_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned FW    = 4;
    localparam int unsigned FRAME = 16;
    localparam int unsigned NPW   = AW + 1;

`ifdef RLE_CTRL_OVERFLOW_CHECK_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [AW:0]    num_pairs = '0;
    logic           cmem_rd;
    logic [AW-1:0]  cmem_addr;
    logic [7:0]     cmem_pixel = '0;
    logic [7:0]     cmem_count = '0;
    logic [7:0]     dec_data;
    logic [7:0]     dec_count;
    logic           dec_valid;
    logic [7:0]     dec_pixel;
    logic           dec_valid_out;
    logic           fb_we;
    logic [FW-1:0]  fb_addr;
    logic [7:0]     fb_data;
    logic           busy;
    logic           done;
    logic           error;
    logic [FW:0]    pix_total;

    rle_decode_ctrl #(
        .ADDR_W       (AW),
        .FB_ADDR_W    (FW),
        .FRAME_PIXELS (FRAME)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_pairs     (num_pairs),
        .cmem_rd       (cmem_rd),
        .cmem_addr     (cmem_addr),
        .cmem_pixel    (cmem_pixel),
        .cmem_count    (cmem_count),
        .dec_data      (dec_data),
        .dec_count     (dec_count),
        .dec_valid     (dec_valid),
        .dec_pixel     (dec_pixel),
        .dec_valid_out (dec_valid_out),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pix_total     (pix_total)
    );

    always #5 clk = ~clk;

    // Compressed memory: data one cycle after the read strobe
    logic [7:0] mem_pix [16];
    logic [7:0] mem_cnt [16];
    always @(posedge clk) begin
        if (cmem_rd) begin
            cmem_pixel <= mem_pix[cmem_addr];
            cmem_count <= mem_cnt[cmem_addr];
        end
    end

    // Decoder: after a valid_in beat, emits count pixels one per cycle
    logic [7:0] m_rem, m_pix;
    logic       m_valid;
    logic       spur = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem   <= '0;
            m_pix   <= '0;
            m_valid <= 1'b0;
        end else if (dec_valid) begin
            m_rem   <= dec_count;
            m_pix   <= dec_data;
            m_valid <= 1'b0;
        end else if (m_rem != 8'd0) begin
            m_valid <= 1'b1;
            m_rem   <= m_rem - 8'd1;
        end else begin
            m_valid <= 1'b0;
        end
    end
    assign dec_valid_out = m_valid | spur;
    assign dec_pixel     = m_pix;

    // Event monitor: write log {addr, data} and strobe counters
    logic [FW+7:0] wlog [$];
    int n_rd = 0;
    int n_dv = 0;
    int n_done = 0;
    always @(posedge clk) begin
        if (fb_we)     wlog.push_back({fb_addr, fb_data});
        if (cmem_rd)   n_rd   <= n_rd + 1;
        if (dec_valid) n_dv   <= n_dv + 1;
        if (done)      n_done <= n_done + 1;
    end

    typedef struct packed {
        int              np;
        logic [7:0][15:0] pr;      // {pixel, count}
        int              exp_n;
        int              exp_total;
        int              exp_err;
        int              exp_rd;
        int              exp_dv;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // k-th pixel of the expanded frame
    function automatic int exp_pix(input vec_t v, input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < v.np) begin
                if (k < acc + int'(v.pr[i][7:0])) return int'(v.pr[i][15:8]);
                acc += int'(v.pr[i][7:0]);
            end
        end
        return -1;
    endfunction

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            mem_pix[i] = (i < 8) ? v.pr[i][15:8] : 8'h00;
            mem_cnt[i] = (i < 8) ? v.pr[i][7:0]  : 8'h00;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cmem_rd"},   int'(cmem_rd),   0);
        chk({tag, " cmem_addr"}, int'(cmem_addr), 0);
        chk({tag, " dec_valid"}, int'(dec_valid), 0);
        chk({tag, " dec_data"},  int'(dec_data),  0);
        chk({tag, " dec_count"}, int'(dec_count), 0);
        chk({tag, " fb_we"},     int'(fb_we),     0);
        chk({tag, " fb_addr"},   int'(fb_addr),   0);
        chk({tag, " fb_data"},   int'(fb_data),   0);
        chk({tag, " busy"},      int'(busy),      0);
        chk({tag, " done"},      int'(done),      0);
        chk({tag, " error"},     int'(error),     0);
        chk({tag, " pix_total"}, int'(pix_total), 0);
    endtask

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " done seen"}, int'(done === 1'b1), 1);
    endtask

    // Let the decoder model run dry so stale pixels cannot leak into the next frame
    task automatic settle();
        int c;
        c = 0;
        @(negedge clk);
        while ((m_rem != 8'd0 || m_valid) && c < 600) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
    endtask

    // Run one frame; glitch pulses a second start mid-frame
    task automatic do_frame(input string nm, input int np, input bit glitch);
        int c;
        @(negedge clk);
        num_pairs = NPW'(np);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
            if (glitch) begin
                start = (c == 6);
                if (c == 6) num_pairs = '0;
            end
        end
        start = 1'b0;
        chk({nm, " done seen"}, int'(done === 1'b1), 1);
        @(negedge clk);
        chk({nm, " done one cycle"}, int'(done), 0);
        settle();
    endtask

    task automatic chk_frame(input string nm, input vec_t v, input int bw,
                             input int brd, input int bdv, input int bdn);
        int nw;
        nw = wlog.size() - bw;
        chk({nm, " writes"}, nw, v.exp_n);
        for (int k = 0; k < v.exp_n; k++) begin
            if (k < nw) begin
                chk($sformatf("%s wr%0d addr", nm, k), int'(wlog[bw+k][FW+7:8]), k % (1 << FW));
                chk($sformatf("%s wr%0d data", nm, k), int'(wlog[bw+k][7:0]), exp_pix(v, k));
            end
        end
        chk({nm, " pix_total"}, int'(pix_total), v.exp_total);
        chk({nm, " error"},     int'(error),     v.exp_err);
        chk({nm, " cmem_rd n"}, n_rd - brd,      v.exp_rd);
        chk({nm, " dec_valid n"}, n_dv - bdv,    v.exp_dv);
        chk({nm, " done n"},    n_done - bdn,    1);
        chk({nm, " busy"},      int'(busy),      0);
    endtask

    initial begin
        int bw, brd, bdv, bdn, c;

        // Frame table: pairs {pixel,count}, expected writes/total/error/reads/decoder beats
        vecs[0] = '0; vecs[0].np = 4;
        vecs[0].pr[0] = 16'h0102; vecs[0].pr[1] = 16'h0203;
        vecs[0].pr[2] = 16'h0301; vecs[0].pr[3] = 16'h0402;
        vecs[0].exp_n = 8; vecs[0].exp_total = 8; vecs[0].exp_err = 0;
        vecs[0].exp_rd = 4; vecs[0].exp_dv = 4;

        vecs[1] = '0; vecs[1].np = 3;
        vecs[1].pr[0] = 16'hAA01; vecs[1].pr[1] = 16'hBB00; vecs[1].pr[2] = 16'hCC02;
        vecs[1].exp_n = 3; vecs[1].exp_total = 3; vecs[1].exp_err = 0;
        vecs[1].exp_rd = 3; vecs[1].exp_dv = 2;

        vecs[2] = '0; vecs[2].np = 0;
        vecs[2].exp_n = 0; vecs[2].exp_total = 0; vecs[2].exp_err = 0;
        vecs[2].exp_rd = 0; vecs[2].exp_dv = 0;

        vecs[3] = '0; vecs[3].np = 2;
        vecs[3].pr[0] = 16'h110A; vecs[3].pr[1] = 16'h220A;
        vecs[3].exp_n = OVF ? 16 : 20; vecs[3].exp_total = OVF ? 16 : 20;
        vecs[3].exp_err = OVF ? 1 : 0; vecs[3].exp_rd = 2; vecs[3].exp_dv = 2;

        vecs[4] = '0; vecs[4].np = 1;
        vecs[4].pr[0] = 16'h5528;
        vecs[4].exp_n = OVF ? 16 : 40; vecs[4].exp_total = OVF ? 16 : 31;
        vecs[4].exp_err = OVF ? 1 : 0; vecs[4].exp_rd = 1; vecs[4].exp_dv = 1;

        vecs[5] = '0; vecs[5].np = 1;
        vecs[5].pr[0] = 16'h7E01;
        vecs[5].exp_n = 1; vecs[5].exp_total = 1; vecs[5].exp_err = 0;
        vecs[5].exp_rd = 1; vecs[5].exp_dv = 1;

        vecs[6] = '0; vecs[6].np = 3;
        vecs[6].pr[0] = 16'h0000; vecs[6].pr[1] = 16'h5A03; vecs[6].pr[2] = 16'hA500;
        vecs[6].exp_n = 3; vecs[6].exp_total = 3; vecs[6].exp_err = 0;
        vecs[6].exp_rd = 3; vecs[6].exp_dv = 1;

        load_mem(vecs[0]);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        // Start/read/issue/write latencies on the basic frame
        start = 1'b1;
        num_pairs = NPW'(4);
        @(negedge clk);
        start = 1'b0;
        chk("t cmem_rd 1cyc", int'(cmem_rd), 1);
        chk("t cmem_addr", int'(cmem_addr), 0);
        chk("t busy", int'(busy), 1);
        @(negedge clk);
        chk("t cmem_rd single", int'(cmem_rd), 0);
        chk("t dec_valid early", int'(dec_valid), 0);
        @(negedge clk);
        chk("t dec_valid 2cyc", int'(dec_valid), 1);
        chk("t dec_data", int'(dec_data), 8'h01);
        chk("t dec_count", int'(dec_count), 2);
        @(negedge clk);
        chk("t dec_valid pulse", int'(dec_valid), 0);
        c = 0;
        while (dec_valid_out !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t dec_valid_out seen", int'(dec_valid_out === 1'b1), 1);
        chk("t fb_we before", int'(fb_we), 0);
        @(negedge clk);
        chk("t fb_we after", int'(fb_we), 1);
        chk("t fb_data", int'(fb_data), 8'h01);
        chk("t fb_addr", int'(fb_addr), 0);
        wait_done("t");
        settle();

        // Empty frame: done two cycles after start, busy drops with it
        @(negedge clk);
        start = 1'b1;
        num_pairs = '0;
        @(negedge clk);
        start = 1'b0;
        chk("e done early", int'(done), 0);
        chk("e busy", int'(busy), 1);
        chk("e cmem_rd", int'(cmem_rd), 0);
        @(negedge clk);
        chk("e done 2cyc", int'(done), 1);
        chk("e busy drop", int'(busy), 0);
        @(negedge clk);
        chk("e done pulse", int'(done), 0);
        settle();

        for (int v = 0; v < NV; v++) begin
            load_mem(vecs[v]);
            bw = wlog.size(); brd = n_rd; bdv = n_dv; bdn = n_done;
            do_frame($sformatf("v%0d", v), vecs[v].np, 1'b0);
            chk_frame($sformatf("v%0d", v), vecs[v], bw, brd, bdv, bdn);
        end

        // Start while busy is ignored
        load_mem(vecs[0]);
        bw = wlog.size(); brd = n_rd; bdv = n_dv; bdn = n_done;
        do_frame("busy_start", 4, 1'b1);
        chk_frame("busy_start", vecs[0], bw, brd, bdv, bdn);

        // Stray decoder valid while idle changes nothing
        bw = wlog.size();
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur writes", wlog.size() - bw, 0);
        chk("spur pix_total", int'(pix_total), 8);
        chk("spur fb_addr", int'(fb_addr), 7);
        chk("spur busy", int'(busy), 0);

        // Reset during the second pair's drain, then a clean rerun
        load_mem(vecs[0]);
        bw = wlog.size();
        @(negedge clk);
        start = 1'b1;
        num_pairs = NPW'(4);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while ((wlog.size() - bw) < 3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("mid writes before rst", wlog.size() - bw, 3);
        chk("mid busy before rst", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk_idle("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        settle();
        chk_idle("mid_rst_released");
        chk("mid no done", n_done - bdn, 1);
        bw = wlog.size(); brd = n_rd; bdv = n_dv; bdn = n_done;
        do_frame("rerun", 4, 1'b0);
        chk_frame("rerun", vecs[0], bw, brd, bdv, bdn);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
